execute_stage_mc: RTL and testbench
===================================

Name: execute_stage_mc

Overview:
Parametrised, handshaked successor to the single-cycle execute unit. It accepts one decoded operation per handshake and executes RV32I ALU ops in one cycle. RV32M mul/div ops run on an iterative unit over multiple cycles. It sits between the decode/operand-select stage and writeback, with valid/ready flow control on both sides and a flush input for branch redirects.

Parameters:
XLEN, 32, datapath width; must be a power of two, at least 8.
ENABLE_M, 1, 1 = implement the M extension; 0 = M opcodes complete as illegal.
OP_W, 5, opcode width; fixed by the package enum.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
flush  in  1  abort the in-flight op and drop the output register
in_valid  in  1  upstream op valid
in_ready  out  1  stage can accept an op
in_op  in  OP_W  exec_pkg::op_e opcode
in_a  in  XLEN  operand 1 (rs1 value)
in_b  in  XLEN  operand 2 (rs2 value or immediate)
in_rd  in  5  destination register index
in_wr  in  1  op writes rd
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_result  out  XLEN  result
out_rd  out  5  destination index
out_wr  out  1  write-rd flag
out_illegal  out  1  M op issued while ENABLE_M=0
busy  out  1  iterative unit active

Behaviour:
- Reset: rst_n low at a clk edge clears all of out_valid, out_result, out_rd, out_wr, out_illegal and busy to 0, and puts the FSM in IDLE. Reset aborts any in-flight op with no output.
- Acceptance: in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush. An op is accepted when in_valid && in_ready at a clk edge.
- FSM states: IDLE, ITER, FIX.
  - IDLE -> ITER on acceptance of an M op when ENABLE_M=1.
  - ITER -> FIX after exactly XLEN iteration cycles.
  - FIX -> IDLE; the output register loads in this cycle.
- ALU ops (ADD SUB SLL SLT SLTU XOR SRL SRA OR AND): accepted at cycle N; out_valid is high at N+1. Full throughput of one op per cycle while out_ready is high.
- M ops: accepted at cycle N; operands are latched as magnitudes plus sign flags. Radix-2 shift-add multiply or restoring divide runs in cycles N+1..N+XLEN. Sign correction happens in FIX; out_valid is high at N+XLEN+2. busy is high from N+1 through the FIX cycle.
- Shifts use in_b[$clog2(XLEN)-1:0]. Add and subtract wrap modulo 2^XLEN. SLT is signed; SLTU is unsigned.
- MUL returns the low XLEN bits. MULH, MULHSU and MULHU return the high XLEN bits of the 2*XLEN signed×signed, signed×unsigned and unsigned×unsigned products.
- Divide by zero: DIV and DIVU return all-ones; REM and REMU return the dividend.
- Signed overflow (-2^(XLEN-1) / -1): DIV returns the dividend; REM returns 0.
- ENABLE_M=0: an M op completes with ALU latency, with out_illegal=1, out_result=0 and out_wr=0.
- Backpressure: while out_valid && !out_ready, all out_* signals hold stable and in_ready is 0.
- Flush: synchronous and highest priority after reset. At the edge, out_valid clears, the FSM returns to IDLE, the iteration state is discarded and busy clears. An op presented in the same cycle as flush is not accepted. in_ready may rise the cycle after flush.
- out_valid && out_ready with no new op: out_valid clears next cycle.

Decomposition:
- exec_pkg holds:
  - op_e enum: ADD=0, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND=9, MUL=10, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU=17.
  - OP_W=5.
  - is_m_op() function.
- Sub-module exec_muldiv_iter(XLEN): start/done interface, owns the iteration counter and the shift/partial registers. Its done output drives the ITER->FIX transition. The ALU, FSM and output register stay in execute_stage_mc.

Test Plan:
- ADD 5 + 0xFFFFFFF9 accepted at cycle 0 -> out_valid at cycle 1 with result 0xFFFFFFFE. Then hold out_ready=0 for 3 cycles -> outputs stable and in_ready=0 throughout.
- MULH 0x80000000×0x80000000 -> 0x40000000 with out_valid at cycle 34. MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MUL 7×-3 -> 0xFFFFFFEB.
- DIV -7/2 -> 0xFFFFFFFD; REM -7,2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100,7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF; REMU 5,0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
- flush at cycle 10 of a DIV -> out_valid never asserts and busy=0 next cycle. An ADD 1+1 accepted at cycle 12 -> result 2 at cycle 13. rst_n low during ITER -> all outputs 0 after the edge.
- ENABLE_M=0 build, MUL 3×4 -> out_valid at cycle 1 with out_illegal=1, result 0 and out_wr=0.

Source files
------------

// File: rtl/exec_pkg.sv
// exec_pkg: opcode encoding and helpers for the execute stage
package exec_pkg;

    localparam int OP_W = 5;

    typedef enum logic [OP_W-1:0] {
        ADD    = 5'd0,
        SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR,
        AND    = 5'd9,
        MUL    = 5'd10,
        MULH, MULHSU, MULHU, DIV, DIVU, REM,
        REMU   = 5'd17
    } op_e;

    function automatic logic is_m_op(op_e op);
        return op inside {MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU};
    endfunction

endpackage

// File: rtl/exec_muldiv_iter.sv
// exec_muldiv_iter: radix-2 shift-add multiplier and restoring divider on magnitudes
module exec_muldiv_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            start,
    input  logic            is_div,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);
    localparam int CW = $clog2(XLEN);

    logic [CW-1:0]   cnt;
    logic            active;
    logic            div_r;
    logic [XLEN-1:0] m;
    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;
    logic [XLEN+1:0] diff;

    // hi:lo is the product accumulator or the remainder:quotient pair
    always_comb begin
        sum     = {1'b0, hi} + {1'b0, m};
        shifted = {hi, lo[XLEN-1]};
        diff    = {1'b0, shifted} - {2'b0, m};
    end

    assign done = active && cnt == CW'(XLEN-1);

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            active <= 1'b0;
            cnt    <= '0;
        end else if (start) begin
            active <= 1'b1;
            cnt    <= '0;
            div_r  <= is_div;
            m      <= b;
            hi     <= '0;
            lo     <= a;
        end else if (active) begin
            cnt    <= cnt + 1'b1;
            active <= !done;
            if (div_r) begin
                hi <= diff[XLEN+1] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
                lo <= {lo[XLEN-2:0], !diff[XLEN+1]};
            end else begin
                {hi, lo} <= lo[0] ? {sum, lo[XLEN-1:1]} : {1'b0, hi, lo[XLEN-1:1]};
            end
        end
    end

endmodule

// File: rtl/execute_stage_mc.sv
// execute_stage_mc: handshaked RV32I/M execute stage, single-cycle ALU plus iterative mul/div
module execute_stage_mc
    import exec_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [4:0]      in_rd,
    input  logic            in_wr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_rd,
    output logic            out_wr,
    output logic            out_illegal,
    output logic            busy
);
    localparam int SW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, ITER, FIX} state_e;

    state_e            state;
    op_e               op;
    op_e               op_r;
    logic              m_op;
    logic              accept;
    logic              neg_a;
    logic              neg_b;
    logic              neg_ar;
    logic              neg_br;
    logic              b_zero;
    logic              rd_wr;
    logic [4:0]        rd_r;
    logic              done;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic [XLEN-1:0]   alu;
    logic [XLEN-1:0]   hi;
    logic [XLEN-1:0]   lo;
    logic [XLEN-1:0]   md_res;
    logic [2*XLEN-1:0] prod;
    logic [SW-1:0]     sh;

    assign op       = op_e'(in_op);
    assign m_op     = is_m_op(op);
    assign in_ready = state == IDLE && (!out_valid || out_ready) && !flush;
    assign accept   = in_valid && in_ready;
    assign busy     = state != IDLE;
    assign sh       = in_b[SW-1:0];

    always_comb begin
        neg_a = in_a[XLEN-1] && op inside {MUL, MULH, MULHSU, DIV, REM};
        neg_b = in_b[XLEN-1] && op inside {MUL, MULH, DIV, REM};
        a_mag = neg_a ? -in_a : in_a;
        b_mag = neg_b ? -in_b : in_b;
    end

    always_comb begin
        case (op)
            ADD:     alu = in_a + in_b;
            SUB:     alu = in_a - in_b;
            SLL:     alu = in_a << sh;
            SLT:     alu = XLEN'($signed(in_a) < $signed(in_b));
            SLTU:    alu = XLEN'(in_a < in_b);
            XOR:     alu = in_a ^ in_b;
            SRL:     alu = in_a >> sh;
            SRA:     alu = $signed(in_a) >>> sh;
            OR:      alu = in_a | in_b;
            AND:     alu = in_a & in_b;
            default: alu = '0;
        endcase
    end

    exec_muldiv_iter #(.XLEN(XLEN)) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (flush),
        .start  (accept && m_op && ENABLE_M),
        .is_div (op inside {DIV, DIVU, REM, REMU}),
        .a      (a_mag),
        .b      (b_mag),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    // signed division by zero must not be sign-corrected away from all-ones
    assign prod = (neg_ar ^ neg_br) ? -{hi, lo} : {hi, lo};

    always_comb begin
        case (op_r)
            MUL:                 md_res = prod[XLEN-1:0];
            MULH, MULHSU, MULHU: md_res = prod[2*XLEN-1:XLEN];
            DIV, DIVU:           md_res = b_zero ? '1 : (neg_ar ^ neg_br) ? -lo : lo;
            default:             md_res = neg_ar ? -hi : hi;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_rd      <= '0;
            out_wr      <= 1'b0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    if (m_op && ENABLE_M) begin
                        state  <= ITER;
                        op_r   <= op;
                        neg_ar <= neg_a;
                        neg_br <= neg_b;
                        b_zero <= in_b == '0;
                        rd_r   <= in_rd;
                        rd_wr  <= in_wr;
                    end else begin
                        out_valid   <= 1'b1;
                        out_result  <= m_op ? '0 : alu;
                        out_rd      <= in_rd;
                        out_wr      <= in_wr && !m_op;
                        out_illegal <= m_op;
                    end
                end
                ITER: if (done) state <= FIX;
                FIX: begin
                    state       <= IDLE;
                    out_valid   <= 1'b1;
                    out_result  <= md_res;
                    out_rd      <= rd_r;
                    out_wr      <= rd_wr;
                    out_illegal <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_execute_stage_mc.sv
// tb_execute_stage_mc: directed and randomized checks of the execute stage against a behavioural model
`timescale 1ns/1ps
module tb_execute_stage_mc;
    import exec_pkg::*;

    localparam int X = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_wr = 1'b0;
    logic         out_ready = 1'b1;
    logic [4:0]   in_op = '0;
    logic [4:0]   in_rd = '0;
    logic [X-1:0] in_a = '0;
    logic [X-1:0] in_b = '0;
    logic         in_ready, out_valid, out_wr, out_illegal, busy;
    logic [X-1:0] out_result;
    logic [4:0]   out_rd;

    logic         z_valid = 1'b0;
    logic         z_wr = 1'b0;
    logic [4:0]   z_op = '0;
    logic [X-1:0] z_a = '0;
    logic [X-1:0] z_b = '0;
    logic         z_in_ready, z_out_valid, z_out_wr, z_out_illegal, z_busy;
    logic [X-1:0] z_result;
    logic [4:0]   z_rd;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    execute_stage_mc #(.XLEN(X), .ENABLE_M(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_rd(in_rd), .in_wr(in_wr),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rd(out_rd), .out_wr(out_wr), .out_illegal(out_illegal), .busy(busy)
    );

    execute_stage_mc #(.XLEN(X), .ENABLE_M(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(1'b0),
        .in_valid(z_valid), .in_ready(z_in_ready), .in_op(z_op),
        .in_a(z_a), .in_b(z_b), .in_rd(5'd3), .in_wr(z_wr),
        .out_valid(z_out_valid), .out_ready(1'b1), .out_result(z_result),
        .out_rd(z_rd), .out_wr(z_out_wr), .out_illegal(z_out_illegal), .busy(z_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    task automatic check(input string name, input logic [X-1:0] act, input logic [X-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // RISC-V semantics written directly from the ISA rules
    function automatic logic [X-1:0] ref_result(input logic [4:0] opc, input logic [X-1:0] a, input logic [X-1:0] b);
        int          sa = a;
        int          sb = b;
        longint      la = sa;
        longint      lb = sb;
        logic [63:0] ua = {32'b0, a};
        logic [63:0] ub = {32'b0, b};
        logic [63:0] p;
        logic        ovf = a == 32'h8000_0000 && b == '1;
        case (op_e'(opc))
            ADD:    return a + b;
            SUB:    return a - b;
            SLL:    return a << b[4:0];
            SLT:    return (sa < sb) ? 1 : 0;
            SLTU:   return (a < b) ? 1 : 0;
            XOR:    return a ^ b;
            SRL:    return a >> b[4:0];
            SRA:    return $signed(a) >>> b[4:0];
            OR:     return a | b;
            AND:    return a & b;
            MUL:    begin p = la * lb; return p[31:0]; end
            MULH:   begin p = la * lb; return p[63:32]; end
            MULHSU: begin p = la * longint'(ub); return p[63:32]; end
            MULHU:  begin p = ua * ub; return p[63:32]; end
            DIV:    begin if (b == 0) return '1; if (ovf) return a; return sa / sb; end
            DIVU:   begin if (b == 0) return '1; return a / b; end
            REM:    begin if (b == 0) return a; if (ovf) return 0; return sa % sb; end
            REMU:   begin if (b == 0) return a; return a % b; end
            default: return 0;
        endcase
    endfunction

    typedef struct {
        int           due;
        logic [X-1:0] res;
        logic [4:0]   rd;
        logic         wr;
    } exp_t;

    exp_t         q[$];
    int           busy_until = -1;
    logic         p_hold = 1'b0;
    logic [X-1:0] p_res;
    logic [4:0]   p_rd;
    logic         p_wr;

    // per-cycle comparison against the transaction-level model
    always @(negedge clk) begin
        logic ev, eb, er, mop;
        exp_t e;
        ev = q.size() > 0 && q[0].due <= cyc;
        eb = cyc <= busy_until;
        er = !eb && (!ev || out_ready) && !flush;
        if (rst_n) begin
            check1("out_valid", out_valid, ev);
            check1("busy", busy, eb);
            check1("in_ready", in_ready, er);
            if (ev) begin
                check("out_result", out_result, q[0].res);
                check("out_rd", {27'b0, out_rd}, {27'b0, q[0].rd});
                check1("out_wr", out_wr, q[0].wr);
                check1("out_illegal", out_illegal, 1'b0);
            end
            if (p_hold) begin
                check("hold result", out_result, p_res);
                check("hold rd", {27'b0, out_rd}, {27'b0, p_rd});
                check1("hold wr", out_wr, p_wr);
            end
        end
        p_hold = rst_n && ev && !out_ready && !flush;
        p_res  = out_result;
        p_rd   = out_rd;
        p_wr   = out_wr;
        if (!rst_n || flush) begin
            q.delete();
            busy_until = -1;
        end else begin
            if (ev && out_ready) void'(q.pop_front());
            if (in_valid && er) begin
                mop   = in_op >= 5'd10 && in_op <= 5'd17;
                e.due = cyc + (mop ? X + 2 : 1);
                e.res = ref_result(in_op, in_a, in_b);
                e.rd  = in_rd;
                e.wr  = in_wr;
                q.push_back(e);
                if (mop) busy_until = cyc + X + 1;
            end
        end
    end

    task automatic issue(input op_e op, input logic [X-1:0] a, input logic [X-1:0] b, output int acc);
        in_op = op; in_a = a; in_b = b; in_rd = 5'd7; in_wr = 1'b1; in_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = cyc;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (acc < 0) begin
            checks++;
            failures++;
            $display("FAIL accept timeout: op %0d never accepted", op);
        end
    endtask

    task automatic run(input string name, input op_e op, input logic [X-1:0] a, input logic [X-1:0] b,
                       input logic [X-1:0] exp, input int lat, output int acc);
        int k;
        issue(op, a, b, acc);
        for (k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        check({name, " latency"}, k, lat);
        check(name, out_result, exp);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [X-1:0] pick();
        case ($urandom_range(0, 7))
            0: return 0;
            1: return 1;
            2: return '1;
            3: return 32'h8000_0000;
            4: return 32'h7fff_ffff;
            5: return $urandom_range(0, 15);
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int acc, c, seen;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check1("reset out_valid", out_valid, 1'b0);
        check1("reset busy", busy, 1'b0);
        check("reset result", out_result, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue(ADD, 5, 32'hFFFF_FFF9, acc);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check1("bp out_valid", out_valid, 1'b1);
            check1("bp in_ready", in_ready, 1'b0);
            check("bp result", out_result, 32'hFFFF_FFFE);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        run("MULH min*min", MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, acc);
        run("MULHU", MULHU, '1, '1, 32'hFFFF_FFFE, 34, acc);
        run("MUL 7*-3", MUL, 7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, acc);
        run("DIV -7/2", DIV, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFD, 34, acc);
        run("REM -7,2", REM, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFF, 34, acc);
        run("DIVU 100/7", DIVU, 100, 7, 14, 34, acc);
        run("REMU 100,7", REMU, 100, 7, 2, 34, acc);
        run("DIVU 5/0", DIVU, 5, 0, '1, 34, acc);
        run("REMU 5,0", REMU, 5, 0, 5, 34, acc);
        run("DIV 5/0", DIV, 5, 0, '1, 34, acc);
        run("DIV ovf", DIV, 32'h8000_0000, '1, 32'h8000_0000, 34, acc);
        run("REM ovf", REM, 32'h8000_0000, '1, 0, 34, acc);
        run("SRA", SRA, 32'h8000_0010, 36, 32'hF800_0001, 1, acc);

        issue(DIV, 1000, 3, c);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        check1("flush in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check1("flush busy", busy, 1'b0);
        check1("flush out_valid", out_valid, 1'b0);
        @(posedge clk);
        #1;
        run("ADD after flush", ADD, 1, 1, 2, 1, acc);
        check("flush add accept cycle", acc, c + 12);
        seen = 0;
        repeat (X + 5) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("no result after flush", seen, 0);
        @(posedge clk);
        #1;

        issue(DIV, 77, 5, acc);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check1("rst iter out_valid", out_valid, 1'b0);
        check1("rst iter busy", busy, 1'b0);
        check("rst iter result", out_result, 0);
        check("rst iter rd", {27'b0, out_rd}, 0);
        check1("rst iter wr", out_wr, 1'b0);
        check1("rst iter illegal", out_illegal, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        z_op = MUL; z_a = 3; z_b = 4; z_wr = 1'b1; z_valid = 1'b1;
        @(negedge clk);
        check1("noM in_ready", z_in_ready, 1'b1);
        @(posedge clk);
        #1;
        z_op = ADD; z_a = 3; z_b = 4;
        @(negedge clk);
        check1("noM mul valid", z_out_valid, 1'b1);
        check1("noM mul illegal", z_out_illegal, 1'b1);
        check("noM mul result", z_result, 0);
        check1("noM mul wr", z_out_wr, 1'b0);
        check1("noM busy", z_busy, 1'b0);
        @(posedge clk);
        #1;
        z_valid = 1'b0;
        @(negedge clk);
        check1("noM add valid", z_out_valid, 1'b1);
        check1("noM add illegal", z_out_illegal, 1'b0);
        check("noM add result", z_result, 7);
        check1("noM add wr", z_out_wr, 1'b1);
        check("noM add rd", {27'b0, z_rd}, 3);
        @(posedge clk);
        #1;

        for (int i = 0; i < 2000; i++) begin
            in_valid  = $urandom_range(0, 2) != 0;
            in_op     = 5'($urandom_range(0, 17));
            in_a      = pick();
            in_b      = pick();
            in_rd     = 5'($urandom());
            in_wr     = 1'($urandom());
            out_ready = $urandom_range(0, 3) != 0;
            flush     = $urandom_range(0, 149) == 0;
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (X + 10) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
